// File: rtl/mem_a_to_b_transfer_pkg.sv
// Shared constants and types for the memory A -> memory B transfer block.
package mem_xfer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DEPTH  = 8;

   localparam logic [DATA_W-1:0] SAT_MAX = '1;

   localparam logic MODE_COPY    = 1'b0;
   localparam logic MODE_PAIRSUM = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : mem_xfer_pkg

// File: rtl/mem_a_to_b_transfer_if.sv
// Control handshake plus memory A read port and memory B write port.
interface mem_a_to_b_transfer_if #(
   parameter int unsigned DATA_W = mem_xfer_pkg::DATA_W,
   parameter int unsigned ADDR_W = mem_xfer_pkg::ADDR_W
);

   logic              start;
   logic              mode;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] AddrA;
   logic              WEA;
   logic [DATA_W-1:0] DOut1;
   logic              WEB;
   logic [ADDR_W-1:0] AddrB;
   logic [DATA_W-1:0] DataInB;

   // Transfer controller side
   modport master (
      input  start, mode, DOut1,
      output busy, done, AddrA, WEA, WEB, AddrB, DataInB
   );

   // Host / memory side
   modport slave (
      output start, mode, DOut1,
      input  busy, done, AddrA, WEA, WEB, AddrB, DataInB
   );

endinterface : mem_a_to_b_transfer_if

// File: rtl/mem_a_to_b_transfer_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry out.
module sat_add #(
   parameter int unsigned DATA_W = mem_xfer_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_sum
);

   logic [DATA_W:0] w_full;

   // Sum in DATA_W+1 bits; the carry selects the clamp value
   always_comb begin
      w_full = {1'b0, i_a} + {1'b0, i_b};
      o_sum  = w_full[DATA_W] ? '1 : w_full[DATA_W-1:0];
   end

endmodule : sat_add

// File: rtl/mem_a_to_b_transfer.sv
// Sequentially reads all of memory A and writes memory B, either as a
// straight copy or as saturating sums of adjacent word pairs.
module mem_a_to_b_transfer #(
   parameter int unsigned DATA_W = mem_xfer_pkg::DATA_W,
   parameter int unsigned ADDR_W = mem_xfer_pkg::ADDR_W,
   parameter int unsigned DEPTH  = mem_xfer_pkg::DEPTH
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_a_to_b_transfer_if.master bus
);

   import mem_xfer_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            r_state,   w_state_nxt;
   logic              r_mode,    w_mode_nxt;
   logic              r_busy,    w_busy_nxt;
   logic              r_done,    w_done_nxt;
   logic [ADDR_W-1:0] r_addr_a,  w_addr_a_nxt;
   // bit 0: DOut1 holds valid data this cycle; bit 1: it did last cycle
   logic [1:0]        r_vld,     w_vld_nxt;
   // index of the memory A word currently on DOut1
   logic [ADDR_W-1:0] r_didx,    w_didx_nxt;
   logic [DATA_W-1:0] r_first,   w_first_nxt;
   logic              r_web,     w_web_nxt;
   logic [ADDR_W-1:0] r_addr_b,  w_addr_b_nxt;
   logic [DATA_W-1:0] r_din_b,   w_din_b_nxt;
   logic [DATA_W-1:0] w_sum;

   sat_add #(.DATA_W(DATA_W)) u_sat_add (
      .i_a   (r_first),
      .i_b   (bus.DOut1),
      .o_sum (w_sum)
   );

   // State and all registered outputs, synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_mode   <= MODE_COPY;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_addr_a <= '0;
         r_vld    <= '0;
         r_didx   <= '0;
         r_first  <= '0;
         r_web    <= 1'b0;
         r_addr_b <= '0;
         r_din_b  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_addr_a <= w_addr_a_nxt;
         r_vld    <= w_vld_nxt;
         r_didx   <= w_didx_nxt;
         r_first  <= w_first_nxt;
         r_web    <= w_web_nxt;
         r_addr_b <= w_addr_b_nxt;
         r_din_b  <= w_din_b_nxt;
      end
   end

   // Sequencing FSM: issue reads, wait for the pipeline to empty, pulse done
   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_addr_a_nxt = r_addr_a;
      w_vld_nxt    = {r_vld[0], 1'b0};
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt  = RUN;
               w_mode_nxt   = bus.mode;
               w_busy_nxt   = 1'b1;
               w_addr_a_nxt = '0;
            end
         end
         RUN: begin
            w_vld_nxt[0] = 1'b1;
            if (r_addr_a == LAST_ADDR) begin
               w_state_nxt = DRAIN;
            end else begin
               w_addr_a_nxt = r_addr_a + 1'b1;
            end
         end
         DRAIN: begin
            // last word was consumed last cycle and nothing is in flight
            if (r_vld == 2'b10) begin
               w_state_nxt = DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         DONE: begin
            w_state_nxt  = IDLE;
            w_addr_a_nxt = '0;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Write path: consume DOut1 and form the memory B write for this word
   always_comb begin
      w_didx_nxt   = r_didx;
      w_first_nxt  = r_first;
      w_web_nxt    = 1'b0;
      w_addr_b_nxt = r_addr_b;
      w_din_b_nxt  = r_din_b;
      if (r_vld[0]) begin
         w_didx_nxt = r_didx + 1'b1;
         if (r_mode == MODE_COPY) begin
            w_web_nxt    = 1'b1;
            w_addr_b_nxt = r_didx;
            w_din_b_nxt  = bus.DOut1;
         end else if (!r_didx[0]) begin
            w_first_nxt = bus.DOut1;
         end else begin
            w_web_nxt    = 1'b1;
            w_addr_b_nxt = r_didx >> 1;
            w_din_b_nxt  = w_sum;
         end
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.AddrA   = r_addr_a;
   assign bus.WEA     = 1'b0;
   assign bus.WEB     = r_web;
   assign bus.AddrB   = r_addr_b;
   assign bus.DataInB = r_din_b;

endmodule : mem_a_to_b_transfer

// File: doc/mem_a_to_b_transfer.md
Name: mem_a_to_b_transfer

Overview:
- Transfer controller directly downstream of memory_A's read port.
- On a start pulse it sequentially reads all DEPTH words of memory A and consumes DOut1.
- It writes the results into a second 8x8 SRAM, memory B, through a matching write port.
- Two modes: straight copy (B[i]=A[i]) and saturating pair-sum (B[k]=sat(A[2k]+A[2k+1])).
- While idle, a top-level mux gives host access to memory A's port (select = busy).

Parameters:
- DATA_W, 8, word width of memories A and B.
- ADDR_W, 3, address width of memories A and B.
- DEPTH, 8, words transferred per run; must equal 2**ADDR_W and be even.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0=copy, 1=pair-sum; sampled with start, held for the run.
- busy  output  1  high from the cycle after start is accepted until the last write completes.
- done  output  1  one-cycle pulse after the final write.
- AddrA  output  ADDR_W  read address to memory A.
- WEA  output  1  write enable to memory A; constant 0 (read only).
- DOut1  input  DATA_W  registered read data from memory A; valid the cycle after AddrA is presented.
- WEB  output  1  write enable to memory B.
- AddrB  output  ADDR_W  write address to memory B.
- DataInB  output  DATA_W  write data to memory B.

Behaviour:
- Clock is clock. Reset is synchronous and active-high, named reset.
- Reset values: busy=0, done=0, AddrA=0, WEA=0, WEB=0, AddrB=0, DataInB=0, state=IDLE, mode register=0.
- All outputs are registered. WEA is tied to 0.
- Cycle numbering: cycle 0 is the cycle start is sampled high in IDLE; cycle n is n edges later.
- FSM state IDLE: waits for start=1. Latches mode and enters RUN.
- FSM state RUN (cycles 1..8):
  - AddrA = 0..7, incremented by a read counter.
  - busy=1.
  - After AddrA=7, goes to DRAIN.
- FSM state DRAIN (cycles 9..10): no new reads; AddrA holds 7; busy=1; pipeline empties.
- FSM state DONE (cycle 11): done=1, busy=0. Returns to IDLE at cycle 12.
- Read pipeline: a 2-bit valid shift register tracks reads. DOut1 holding A[i] is valid in cycle i+2.
- Copy mode:
  - At the edge ending cycle i+2, DataInB<=DOut1, AddrB<=i, WEB<=1.
  - Writes occur in cycles 3..10, one per cycle, addresses 0..7.
- Pair-sum mode:
  - At the edge ending cycle 2k+2, capture A[2k] into a first-operand register.
  - At the edge ending cycle 2k+3, DataInB <= sat(first + DOut1), AddrB <= k, WEB <= 1.
  - Writes occur in cycles 4, 6, 8, 10 to addresses 0..3. B[4..7] are never written. WEB=0 in odd cycles.
- Saturation: the sum is formed in DATA_W+1 bits. If the carry bit is 1, the result is 2**DATA_W-1 (0xFF); otherwise the low DATA_W bits.
- WEB is high for exactly one cycle per write. AddrB/DataInB hold their last values when WEB=0.
- Both modes finish with done in cycle 11.
- start in any state other than IDLE (including DONE) is ignored. A mode change mid-run has no effect.
- Reset mid-run: at the next edge, all outputs return to their reset values and the FSM returns to IDLE.
  - No done pulse is produced. The partial contents of memory B are left as written.
- Counters wrap only at the run end; no address beyond DEPTH-1 is issued.

Decomposition:
- Package mem_xfer_pkg:
  - DATA_W/ADDR_W/DEPTH constants.
  - state encoding (IDLE, RUN, DRAIN, DONE).
  - MODE_COPY=0, MODE_PAIRSUM=1.
  - SAT_MAX constant.
- One sub-module, sat_add: combinational DATA_W saturating adder, reused by later arithmetic stages.

Test Plan:
- Copy: preload A[i]=0x11*i, start with mode=0 -> WEB high in cycles 3..10, B[i]=0x11*i, done=1 only in cycle 11, busy high in cycles 1..10.
- Pair-sum: A={0x01,0x02,0x10,0x20,0x30,0x05,0x7F,0x00}, mode=1 -> B[0..3]={0x03,0x30,0x35,0x7F}, WEB in cycles 4,6,8,10 only, B[4..7] unchanged.
- Saturation: A[0]=0xF0, A[1]=0x20, A[2]=0x80, A[3]=0x80 -> B[0]=0xFF, B[1]=0xFF; also A[4]=0x80, A[5]=0x7F -> B[2]=0xFF.
- Ignored start and mode: pulse start with mode flipped in cycles 5 and 11 -> no restart, original mode kept, exactly one done.
- Reset mid-run: assert reset in cycle 5 -> next cycle all outputs 0, no done. A fresh start then completes a full correct copy.
- Back-to-back: start again in cycle 12 (IDLE) -> accepted; second run's done arrives 11 cycles after that start.
